// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file write arbiter.
//   RF_DEPTH / RF_ADDR_W : register file geometry (8 entries, 3-bit address)
//   arb_state_e          : arbiter state (IDLE: granting writes, CLEAR: zero-fill)
//   next_rr_ptr()        : round-robin pointer advance, modulo the requester count
package reg_file_pkg;

    localparam int unsigned RF_DEPTH  = 8;
    localparam int unsigned RF_ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } arb_state_e;

    // Pointer moves to the requester just after the one that was served.
    function automatic logic [RF_ADDR_W-1:0] next_rr_ptr(input logic [RF_ADDR_W-1:0] g,
                                                         input int unsigned n);
        logic [RF_ADDR_W:0] nxt;
        nxt = {1'b0, g} + (RF_ADDR_W + 1)'(1);
        if (32'(nxt) >= n) begin
            nxt = '0;
        end
        return nxt[RF_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   valid     : request vector
//   ptr       : highest-priority requester this cycle
//   grant     : one-hot grant, zero when nothing is valid
//   grant_idx : index of the granted requester (0 when nothing is valid)
module rr_pick
    import reg_file_pkg::*;
#(
    parameter int unsigned num_req = 4
) (
    input  logic [num_req-1:0]   valid,
    input  logic [RF_ADDR_W-1:0] ptr,
    output logic [num_req-1:0]   grant,
    output logic [RF_ADDR_W-1:0] grant_idx
);

    // Pick the valid requester with the smallest circular distance from ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d    = num_req;
        d         = 0;
        grant_idx = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (i >= 32'(ptr)) begin
                d = i - 32'(ptr);
            end else begin
                d = i + num_req - 32'(ptr);
            end
            if (valid[i] && (d < best_d)) begin
                best_d    = d;
                grant_idx = RF_ADDR_W'(i);
            end
        end
        grant = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            grant[i] = (best_d < num_req) && (32'(grant_idx) == i);
        end
    end

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a zero-fill
// sequencer that writes 0 to all entries on request.
//   clk, reset (sync, active-high)
//   req_valid/req_addr/req_data/req_ready : per-requester valid/ready write channel
//   clear_start : pulse to start a zero-fill; clear_busy high during its 8 writes
//   write_data/write_port/write_enable    : registered drive of the register file
//   grant_count : per-requester 8-bit saturating transfer counters, only present
//                 when WRITE_ARB_GRANT_CNT_EN is defined
module reg_file_write_arbiter
    import reg_file_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned num_req = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_req-1:0]             req_valid,
    input  logic [num_req*RF_ADDR_W-1:0]   req_addr,
    input  logic [num_req*width-1:0]       req_data,
    output logic [num_req-1:0]             req_ready,
    input  logic                           clear_start,
    output logic                           clear_busy,
    output logic [width-1:0]               write_data,
    output logic [RF_ADDR_W-1:0]           write_port,
`ifdef WRITE_ARB_GRANT_CNT_EN
    output logic [num_req*8-1:0]           grant_count,
`endif
    output logic                           write_enable
);

    arb_state_e             state_q, state_d;
    logic [RF_ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [RF_ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                   we_q, we_d;
    logic                   busy_q, busy_d;
    logic [RF_ADDR_W-1:0]   port_q, port_d;
    logic [width-1:0]       data_q, data_d;

    logic [num_req-1:0]     pick_grant;
    logic [RF_ADDR_W-1:0]   pick_idx;
    logic                   xfer;
    logic [RF_ADDR_W-1:0]   sel_addr;
    logic [width-1:0]       sel_data;

    rr_pick #(
        .num_req (num_req)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // clear_start and reset both suppress the grant in the same cycle.
    assign req_ready = (state_q == IDLE && !clear_start && !reset) ? pick_grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
                sel_data = req_data[i*width +: width];
            end
        end
    end

    // State register, including the registered write-port drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            clr_idx_q <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            port_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            clr_idx_q <= clr_idx_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            port_q    <= port_d;
            data_q    <= data_d;
        end
    end

    // Next state. clr_idx holds the address whose zero-write is on the port now.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (xfer) begin
                    rr_ptr_d = next_rr_ptr(pick_idx, num_req);
                end
            end
            CLEAR: begin
                if (clr_idx_q == RF_ADDR_W'(RF_DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + RF_ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next registered outputs, derived from where the FSM is heading.
    always_comb begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        port_d = port_q;
        data_d = data_q;
        if (state_d == CLEAR) begin
            we_d   = 1'b1;
            busy_d = 1'b1;
            port_d = clr_idx_d;
            data_d = '0;
        end else if (xfer) begin
            we_d   = 1'b1;
            port_d = sel_addr;
            data_d = sel_data;
        end
    end

    assign write_enable = we_q;
    assign clear_busy   = busy_q;
    assign write_port   = port_q;
    assign write_data   = data_q;

`ifdef WRITE_ARB_GRANT_CNT_EN
    logic [num_req-1:0][7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && clear_start)) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < num_req; i++) begin
                if (req_ready[i] && (cnt_q[i] != 8'hFF)) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: doc/reg_file_write_arbiter.md
# reg_file_write_arbiter

Round-robin write-port arbiter and clear sequencer for the 8-entry register file (2 read ports, 1 write port). It shares the single write port among `num_req` requesters through a valid/ready handshake. It drives the register file's `write_data`, `write_port` and `write_enable` from registered outputs. On command, it also sequences a zero-fill of all 8 entries. Read ports are untouched and connect directly to the register file.

## Interface
- `width`, 8, data bits per register
- `num_req`, 4, requester count (2..8)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous reset, active-high
- `req_valid`  in  num_req  per-requester write request
- `req_addr`  in  num_req*3  target register; requester i uses bits [3i+2:3i]
- `req_data`  in  num_req*width  write data; requester i uses bits [width*i+width-1:width*i]
- `req_ready`  out  num_req  one-hot or zero; the grant
- `clear_start`  in  1  single-cycle pulse requesting a zero-fill
- `clear_busy`  out  1  high while the zero-fill is in progress
- `write_data`  out  width  to register file
- `write_port`  out  3  to register file
- `write_enable`  out  1  to register file

## Operation
- **Handshake.** A transfer occurs on a rising edge where `req_valid[i] & req_ready[i]`. A requester holds valid, addr and data stable until that edge. Dropping valid without a transfer is allowed.
- **Ready.** `req_ready` is combinational: ready = `state==IDLE & ~clear_start & ~reset`.
  - The grant goes to the first valid requester found by searching from `rr_ptr` upward, wrapping modulo `num_req`.
  - At most one bit of `req_ready` is high. If no requester is valid, all bits are 0.
- **Pointer.** On a transfer by requester g, `rr_ptr` becomes `(g+1) mod num_req`. With no transfer, `rr_ptr` holds.
- **States.** IDLE and CLEAR.
  - IDLE → CLEAR when `clear_start=1`. `clear_start` wins over any simultaneous request; no grant is issued that cycle.
  - In CLEAR, the 3-bit `clr_idx` steps 0..7 and emits one zero-write per cycle. CLEAR → IDLE after index 7 is issued.
  - `clear_start` is ignored while in CLEAR.
- **Registered outputs.**
  - After a transfer: `write_enable=1`, `write_port=req_addr[g]`, `write_data=req_data[g]` for exactly one cycle.
  - In CLEAR: `write_enable=1`, `write_port=clr_idx`, `write_data=0`.
  - Otherwise `write_enable=0`. `write_port` and `write_data` hold their last values.
- `clear_busy` is 1 exactly in the 8 cycles that carry zero-writes.
- **Reset.**
  - `state=IDLE`, `rr_ptr=0`, `clr_idx=0`.
  - `write_enable=0`, `write_port=0`, `write_data=0`, `clear_busy=0`, `req_ready=0`.
  - Reset during CLEAR aborts the fill. Entries already written stay zero; the register file's own reset governs the rest.

## Timing
- **Request latency:** handshake at edge N → outputs valid during cycle N..N+1 → register file commits at edge N+1. A read of that address shows the new data after edge N+1.
- **Throughput:** one write per cycle. Back-to-back grants to different requesters in consecutive cycles are required when all are valid.
- **Clear:** `clear_start` sampled at edge N → zero-writes to addresses 0..7 drive `write_enable` during cycles N+1..N+8 → the first grant is possible in the cycle after the write to address 7.
- **Starvation bound:** a continuously valid requester is granted within `num_req` IDLE cycles.

## Configuration
- `WRITE_ARB_GRANT_CNT_EN` defined:
  - Adds output `grant_count` (num_req*8 bits): one 8-bit saturating counter per requester.
  - Each counter increments on that requester's transfer and saturates at 255.
  - Counters clear on `reset` and on `clear_start` acceptance.
- Undefined: no counters and no port. Behaviour is otherwise identical.

## Structure
- **Package `reg_file_pkg`:**
  - constants `RF_DEPTH=8`, `RF_ADDR_W=3`
  - state typedef {IDLE, CLEAR}
  - function `next_rr_ptr`
- **Sub-module `rr_pick`:** combinational; inputs valid vector and pointer, outputs one-hot grant and grant index. Instantiated once.

## Test plan
- Hold reset 2 cycles, all `req_valid=1` → every output 0, `req_ready=0`; after release, the first grant goes to requester 0.
- Only requester 1 valid, addr 3, data 0x2A → `req_ready=4'b0010` that cycle. Next cycle `write_enable=1`, `write_port=3`, `write_data=0x2A`, then `write_enable=0`. A read port on address 3 shows 0x2A.
- All 4 requesters valid continuously → grants 0,1,2,3,0 on consecutive cycles; `write_enable` stays high throughout.
- `rr_ptr=2`, only requesters 0 and 3 valid → 3 granted first, then 0.
- Pulse `clear_start` while requester 2 is valid → no grant that cycle. `clear_busy` is high for 8 cycles with `write_port` 0..7 and `write_data=0`. Requester 2 is granted the cycle after.
- Assert `reset` during the 4th zero-write (address 3) → next cycle `write_enable=0`, `clear_busy=0`, state IDLE, `rr_ptr=0`.
